// File: rtl/branch_predictor_if.sv
// branch_predictor_if: request, prediction and branch-resolution signals of the gshare predictor.
// master = fetch/resolve side, slave = predictor.
interface branch_predictor_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int GHR_WIDTH  = 4
);
  logic                  reqValid;
  logic [ADDR_WIDTH-1:0] reqPc;
  logic                  reqIsBranch;
  logic                  predValid;
  logic                  predIsNextPcPredicted;
  logic [ADDR_WIDTH-1:0] predNextPc;
  logic                  predTaken;
  logic [GHR_WIDTH-1:0]  predGhr;
  logic                  updValid;
  logic [ADDR_WIDTH-1:0] updPc;
  logic                  updTaken;
  logic [ADDR_WIDTH-1:0] updTarget;
  logic [GHR_WIDTH-1:0]  updGhr;
  logic                  updMispredict;
  modport master (
    output reqValid, reqPc, reqIsBranch, updValid, updPc, updTaken, updTarget, updGhr, updMispredict,
    input  predValid, predIsNextPcPredicted, predNextPc, predTaken, predGhr
  );
  modport slave (
    input  reqValid, reqPc, reqIsBranch, updValid, updPc, updTaken, updTarget, updGhr, updMispredict,
    output predValid, predIsNextPcPredicted, predNextPc, predTaken, predGhr
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: gshare direction predictor with speculative GHR and registered prediction record.
// Define BRANCH_PREDICTOR_BTB_EN to add the direct-mapped BTB supplying taken targets.
module branch_predictor #(
  parameter int ADDR_WIDTH      = 32,
  parameter int GHR_WIDTH       = 4,
  parameter int PHT_INDEX_WIDTH = 6,
  parameter int BTB_INDEX_WIDTH = 4,
  parameter int BTB_TAG_WIDTH   = 8
) (
  input logic clk,
  input logic rstN,
  branch_predictor_if.slave bp
);
  localparam int PHT_N = 1 << PHT_INDEX_WIDTH;
  logic [GHR_WIDTH-1:0]       ghr_q, ghr_d;
  logic [1:0]                 pht_q [PHT_N];
  logic [1:0]                 pht_d;
  logic [PHT_INDEX_WIDTH-1:0] req_idx, upd_idx;
  logic                       taken, btb_hit;
  logic [ADDR_WIDTH-1:0]      btb_tgt;
  logic                       pred_valid_q, pred_np_q, pred_np_d, pred_taken_q;
  logic [ADDR_WIDTH-1:0]      pred_pc_q, pred_pc_d;
  logic [GHR_WIDTH-1:0]       pred_ghr_q;
  assign req_idx = bp.reqPc[PHT_INDEX_WIDTH+1:2] ^ PHT_INDEX_WIDTH'(ghr_q);
  assign upd_idx = bp.updPc[PHT_INDEX_WIDTH+1:2] ^ PHT_INDEX_WIDTH'(bp.updGhr);
  assign taken   = bp.reqIsBranch & pht_q[req_idx][1];
`ifdef BRANCH_PREDICTOR_BTB_EN
  localparam int BTB_N = 1 << BTB_INDEX_WIDTH;
  logic                       btb_v_q   [BTB_N];
  logic [BTB_TAG_WIDTH-1:0]   btb_tag_q [BTB_N];
  logic [ADDR_WIDTH-1:0]      btb_tgt_q [BTB_N];
  logic [BTB_INDEX_WIDTH-1:0] req_bi, upd_bi;
  assign req_bi  = bp.reqPc[BTB_INDEX_WIDTH+1:2];
  assign upd_bi  = bp.updPc[BTB_INDEX_WIDTH+1:2];
  assign btb_hit = btb_v_q[req_bi] && (btb_tag_q[req_bi] == bp.reqPc[BTB_INDEX_WIDTH+2 +: BTB_TAG_WIDTH]);
  assign btb_tgt = btb_tgt_q[req_bi];
  always_ff @(posedge clk or negedge rstN)
    if (!rstN)
      for (int i = 0; i < BTB_N; i++) btb_v_q[i] <= 1'b0;
    else if (bp.updValid && bp.updTaken)
      btb_v_q[upd_bi] <= 1'b1;
  // Tag and target storage needs no reset; the valid bit guards it.
  always_ff @(posedge clk)
    if (bp.updValid && bp.updTaken) begin
      btb_tag_q[upd_bi] <= bp.updPc[BTB_INDEX_WIDTH+2 +: BTB_TAG_WIDTH];
      btb_tgt_q[upd_bi] <= bp.updTarget;
    end
`else
  assign btb_hit = 1'b0;
  assign btb_tgt = '0;
`endif
  always_comb begin
    pht_d     = bp.updTaken ? ((pht_q[upd_idx] == 2'b11) ? 2'b11 : pht_q[upd_idx] + 2'b01)
                            : ((pht_q[upd_idx] == 2'b00) ? 2'b00 : pht_q[upd_idx] - 2'b01);
    pred_np_d = bp.reqIsBranch & (~taken | btb_hit);
    pred_pc_d = !bp.reqIsBranch ? '0 : !taken ? bp.reqPc + ADDR_WIDTH'(4) : btb_hit ? btb_tgt : '0;
    // Mispredict repair wins over the speculative shift of a same-cycle request.
    ghr_d     = (bp.updValid & bp.updMispredict) ? {bp.updGhr[GHR_WIDTH-2:0], bp.updTaken}
              : (bp.reqValid & bp.reqIsBranch)   ? {ghr_q[GHR_WIDTH-2:0], taken}
              : ghr_q;
  end
  always_ff @(posedge clk or negedge rstN)
    if (!rstN)
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
    else if (bp.updValid)
      pht_q[upd_idx] <= pht_d;
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_np_q    <= 1'b0;
      pred_pc_q    <= '0;
      pred_taken_q <= 1'b0;
      pred_ghr_q   <= '0;
    end else begin
      ghr_q        <= ghr_d;
      pred_valid_q <= bp.reqValid;
      if (bp.reqValid) begin
        pred_np_q    <= pred_np_d;
        pred_pc_q    <= pred_pc_d;
        pred_taken_q <= taken;
        pred_ghr_q   <= ghr_q;
      end
    end
  assign bp.predValid             = pred_valid_q;
  assign bp.predIsNextPcPredicted = pred_np_q;
  assign bp.predNextPc            = pred_pc_q;
  assign bp.predTaken             = pred_taken_q;
  assign bp.predGhr               = pred_ghr_q;
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised gshare direction predictor with a direct-mapped BTB and a speculative global history register (GHR).
- Sits in the fetch unit, between PC generation and the fetch pipeline register.
- Takes a fetch PC plus a predecode "is branch" flag and produces a registered branch-prediction record: next-PC-predicted flag, predicted next PC, taken flag, history snapshot.
- Trained by the branch-resolution update port; repairs the GHR on mispredict.

Parameters:
- ADDR_WIDTH, 32, PC width in bits.
- GHR_WIDTH, 4, global history length; also the snapshot width.
- PHT_INDEX_WIDTH, 6, log2 of PHT entries; must be >= GHR_WIDTH.
- BTB_INDEX_WIDTH, 4, log2 of BTB entries.
- BTB_TAG_WIDTH, 8, stored tag bits, taken from PC[BTB_INDEX_WIDTH+2 +: BTB_TAG_WIDTH].

Ports:
- clk  in  1  clock.
- rstN  in  1  asynchronous active-low reset.
- reqValid  in  1  prediction request this cycle.
- reqPc  in  ADDR_WIDTH  fetch PC (word aligned).
- reqIsBranch  in  1  predecoded conditional branch.
- predValid  out  1  registered prediction valid.
- predIsNextPcPredicted  out  1  predictedNextPc is usable.
- predNextPc  out  ADDR_WIDTH  predicted next PC.
- predTaken  out  1  predicted taken.
- predGhr  out  GHR_WIDTH  GHR value used to form this prediction.
- updValid  in  1  resolved-branch update.
- updPc  in  ADDR_WIDTH  PC of the resolved branch.
- updTaken  in  1  actual direction.
- updTarget  in  ADDR_WIDTH  actual taken target.
- updGhr  in  GHR_WIDTH  predGhr returned with the branch.
- updMispredict  in  1  direction or target mispredicted.

Behaviour:
- Reset (async, rstN=0):
  - all outputs 0;
  - GHR = 0;
  - all PHT counters = 2'b01 (weakly not taken);
  - all BTB valid bits = 0.
  - Reset mid-operation discards any in-flight prediction.
- PHT index = reqPc[PHT_INDEX_WIDTH+1:2] XOR zero-extended GHR. The update path uses updPc and updGhr the same way.
- Prediction latency is 1 cycle. All pred* outputs are registered and update only when reqValid=1. When reqValid=0, predValid=0 and the other outputs hold.
- Output cases:
  - reqIsBranch=0: IsNextPcPredicted=0, NextPc=0, Taken=0.
  - Branch, counter MSB=0: IsNextPcPredicted=1, NextPc=reqPc+4 (wraps mod 2^ADDR_WIDTH), Taken=0.
  - Branch, counter MSB=1, BTB hit (valid and tag match): IsNextPcPredicted=1, NextPc=BTB target, Taken=1.
  - Branch, counter MSB=1, BTB miss: IsNextPcPredicted=0, NextPc=0, Taken=1.
- predGhr = GHR before any shift for this request.
- Speculative history: on reqValid&reqIsBranch, GHR <= {GHR[GHR_WIDTH-2:0], predicted taken}.
- Update, when updValid=1:
  - PHT counter saturating ±1 toward updTaken; stays at 2'b11 and 2'b00.
  - If updTaken=1, BTB entry written with valid=1, tag, updTarget. Not-taken updates leave the BTB unchanged.
- Recovery: updValid&updMispredict sets GHR <= {updGhr[GHR_WIDTH-2:0], updTaken}. This has priority over a same-cycle speculative shift, which is dropped. The prediction output for that cycle is still produced normally.
- Same-cycle read and write to the same PHT or BTB index: the read sees the old (pre-update) value.

Optional Feature:
- BRANCH_PREDICTOR_BTB_EN defined: BTB storage and the hit path as above.
- Undefined: no BTB storage. Every predicted-taken branch gives IsNextPcPredicted=0, NextPc=0, Taken=1. BTB writes are ignored.

Test Plan:
- Reset then reqValid=1, reqPc=0x100, reqIsBranch=1 → next cycle predValid=1, Taken=0, NextPc=0x104, IsNextPcPredicted=1, predGhr=0; GHR becomes 0.
- Two updates (updPc=0x100, updGhr=0, updTaken=1, updTarget=0x200), then request at 0x100 with GHR=0 → Taken=1, NextPc=0x200, IsNextPcPredicted=1 (BTB_EN) / IsNextPcPredicted=0, NextPc=0 (no BTB_EN).
- Four taken updates at the same index, then three not-taken → counter goes 01→11 (saturated), then 11→00; request predicts Taken=0.
- GHR at 4'b1010 with a speculative taken prediction in the same cycle as updMispredict=1, updGhr=4'b0011, updTaken=0 → GHR=4'b0110, not 4'b0101.
- reqPc=0xFFFFFFFC, branch, counter weak → NextPc=0x00000000.
- Assert rstN low for 1 cycle between a request and its output → predValid=0, GHR=0, BTB empty (later taken prediction gives BTB miss).
